// File: rtl/clause_unit_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, hold-until-release
// semantics and an optional watchdog that forces a hung holder off the resource.

// One-hot to binary encoder; none flags an all-zero input.
module clause_unit_arbiter_enc #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          none
);

  // OR-reduce the positions of the set bits; exact for a one-hot input.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) idx = idx | IW'(i);
    end
    none = (onehot == '0);
  end

endmodule

module clause_unit_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16,
  localparam int IW     = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] busy_cnt
);

  localparam int PW = IW + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [N-1:0]     gnt_n;
  logic [CNT_W-1:0] cnt_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic             timeout_n;

  logic             gnt_none;
  logic [IW-1:0]    holder_next;
  logic             rel_done, rel_wd, rel_to, rel_any, to_only;
  logic [IW-1:0]    base;
  logic [N-1:0]     cand;
  logic [PW-1:0]    pos;
  logic             win_found;
  logic [IW-1:0]    win_idx;

  clause_unit_arbiter_enc #(.N(N), .IW(IW)) u_enc (
    .onehot (gnt),
    .idx    (gnt_idx),
    .none   (gnt_none)
  );

  assign gnt_valid = ~gnt_none;

  // Release causes and the priority base for the following search.
  always_comb begin
    holder_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    rel_done    = done;
    rel_wd      = ((req & gnt) == '0);
    rel_to      = (TIMEOUT != 0) && (busy_cnt == CNT_W'(TIMEOUT));
    rel_any     = (state == BUSY) && (rel_done || rel_wd || rel_to);
    to_only     = (state == BUSY) && rel_to && !rel_done && !rel_wd;
    base        = (state == BUSY) ? holder_next : ptr;
    // A watchdog-forced holder sits out the re-arbitration on its release
    // edge, so it cannot be handed the resource back without a gap.
    cand        = to_only ? (req & ~gnt) : req;
  end

  // First candidate in circular order starting at base, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, base} + PW'(i);
      if (pos >= PW'(N)) pos = pos - PW'(N);
      if (!win_found && cand[pos[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[IW-1:0];
      end
    end
  end

  // Next-state, grant, pointer and counter selection.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    cnt_n     = busy_cnt;
    ptr_n     = ptr;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt_n          = '0;
          gnt_n[win_idx] = 1'b1;
          cnt_n          = CNT_W'(1);
          state_n        = BUSY;
        end
      end
      BUSY: begin
        if (rel_any) begin
          ptr_n     = holder_next;
          timeout_n = to_only;
          if (win_found) begin
            gnt_n          = '0;
            gnt_n[win_idx] = 1'b1;
            cnt_n          = CNT_W'(1);
          end else begin
            gnt_n   = '0;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else if (busy_cnt != '1) begin
          cnt_n = busy_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= '0;
      busy_cnt <= '0;
      ptr      <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      busy_cnt <= cnt_n;
      ptr      <= ptr_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_clause_unit_arbiter.sv
module tb_clause_unit_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b1;

  logic [7:0]  req8 = '0;
  logic        done8 = 1'b0;
  logic [7:0]  gnt8;
  logic [2:0]  idx8;
  logic        v8, to8;
  logic [15:0] cnt8;

  logic [6:0]  req7 = '0;
  logic        done7 = 1'b0;
  logic [6:0]  gnt7;
  logic [2:0]  idx7;
  logic        v7, to7;
  logic [3:0]  cnt7;

  clause_unit_arbiter #(.N(8), .TIMEOUT(16), .CNT_W(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .req(req8), .done(done8),
    .gnt(gnt8), .gnt_idx(idx8), .gnt_valid(v8), .timeout(to8), .busy_cnt(cnt8)
  );

  clause_unit_arbiter #(.N(7), .TIMEOUT(0), .CNT_W(4)) dut7 (
    .clk(clk), .reset_n(reset_n), .req(req7), .done(done7),
    .gnt(gnt7), .gnt_idx(idx7), .gnt_valid(v7), .timeout(to7), .busy_cnt(cnt7)
  );

  // Reference model: holder index (-1 when idle), priority pointer, hold count.
  typedef struct {
    int holder;
    int ptr;
    int cnt;
    bit to;
  } mstate_t;

  mstate_t m8, m7;
  int n_pass  = 0;
  int n_total = 0;

  function automatic mstate_t model_reset();
    mstate_t s;
    s.holder = -1;
    s.ptr    = 0;
    s.cnt    = 0;
    s.to     = 1'b0;
    return s;
  endfunction

  function automatic mstate_t model_step(mstate_t s, int n, int tmo, int cmax,
                                         logic [7:0] r, logic d);
    mstate_t o;
    int start, excl, c;
    bit rearb, rd, rw, rt;
    o     = s;
    o.to  = 1'b0;
    excl  = -1;
    start = s.ptr;
    rearb = 1'b1;
    if (s.holder >= 0) begin
      rd = d;
      rw = (r[s.holder] == 1'b0);
      rt = (tmo != 0) && (s.cnt == tmo);
      if (rd || rw || rt) begin
        o.ptr = (s.holder + 1) % n;
        start = o.ptr;
        o.to  = rt && !rd && !rw;
        if (o.to) excl = s.holder;
      end else begin
        rearb = 1'b0;
        o.cnt = (s.cnt < cmax) ? s.cnt + 1 : cmax;
      end
    end
    if (rearb) begin
      o.holder = -1;
      o.cnt    = 0;
      for (int k = 0; k < n; k++) begin
        c = (start + k) % n;
        if (o.holder < 0 && r[c] && c != excl) begin
          o.holder = c;
          o.cnt    = 1;
        end
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_models(input string tag);
    logic [31:0] eg;
    eg = (m8.holder < 0) ? 32'd0 : (32'd1 << m8.holder);
    chk({tag, " n8 gnt"},   {24'd0, gnt8}, eg);
    chk({tag, " n8 idx"},   {29'd0, idx8}, (m8.holder < 0) ? 32'd0 : m8.holder);
    chk({tag, " n8 valid"}, {31'd0, v8},   (m8.holder >= 0) ? 32'd1 : 32'd0);
    chk({tag, " n8 tmo"},   {31'd0, to8},  {31'd0, m8.to});
    chk({tag, " n8 cnt"},   {16'd0, cnt8}, m8.cnt);
    eg = (m7.holder < 0) ? 32'd0 : (32'd1 << m7.holder);
    chk({tag, " n7 gnt"},   {25'd0, gnt7}, eg);
    chk({tag, " n7 idx"},   {29'd0, idx7}, (m7.holder < 0) ? 32'd0 : m7.holder);
    chk({tag, " n7 valid"}, {31'd0, v7},   (m7.holder >= 0) ? 32'd1 : 32'd0);
    chk({tag, " n7 tmo"},   {31'd0, to7},  {31'd0, m7.to});
    chk({tag, " n7 cnt"},   {28'd0, cnt7}, m7.cnt);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m8 = model_step(m8, 8, 16, 65535, req8, done8);
    m7 = model_step(m7, 7, 0, 15, {1'b0, req7}, done7);
    @(negedge clk);
    check_models(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req8 = '0; done8 = 1'b0; req7 = '0; done7 = 1'b0;
    reset_n = 1'b0;
    #1;
    m8 = model_reset();
    m7 = model_reset();
    check_models("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  req;
    logic        done;
    logic [7:0]  gnt;
    logic [2:0]  idx;
    logic        valid;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{8'h05, 1'b0, 8'h01, 3'd0, 1'b1, 16'd1};
    tbl[1]  = '{8'h05, 1'b1, 8'h04, 3'd2, 1'b1, 16'd1};
    tbl[2]  = '{8'h05, 1'b0, 8'h04, 3'd2, 1'b1, 16'd2};
    tbl[3]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 16'd1};
    tbl[4]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 16'd0};
    tbl[5]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 16'd0};
    tbl[6]  = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 16'd1};
    tbl[7]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 16'd1};
    tbl[8]  = '{8'hFF, 1'b1, 8'h40, 3'd6, 1'b1, 16'd1};
    tbl[9]  = '{8'hFF, 1'b1, 8'h80, 3'd7, 1'b1, 16'd1};
    tbl[10] = '{8'hFF, 1'b1, 8'h01, 3'd0, 1'b1, 16'd1};
    tbl[11] = '{8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 16'd1};
    tbl[12] = '{8'h03, 1'b1, 8'h02, 3'd1, 1'b1, 16'd1};
    tbl[13] = '{8'h03, 1'b0, 8'h02, 3'd1, 1'b1, 16'd2};

    m8 = model_reset();
    m7 = model_reset();

    // Directed table on the N=8 instance.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req8  = tbl[i].req;
      done8 = tbl[i].done;
      tick("table");
      chk($sformatf("tbl%0d gnt", i),   {24'd0, gnt8}, {24'd0, tbl[i].gnt});
      chk($sformatf("tbl%0d idx", i),   {29'd0, idx8}, {29'd0, tbl[i].idx});
      chk($sformatf("tbl%0d valid", i), {31'd0, v8},   {31'd0, tbl[i].valid});
      chk($sformatf("tbl%0d tmo", i),   {31'd0, to8},  32'd0);
      chk($sformatf("tbl%0d cnt", i),   {16'd0, cnt8}, {16'd0, tbl[i].cnt});
    end

    // All requesting, done every third cycle: full rotation, never idle.
    do_reset();
    req8 = 8'hFF;
    tick("rot");
    for (int g = 0; g < 9; g++) begin
      chk($sformatf("rot idx g%0d", g), {29'd0, idx8}, g % 8);
      chk("rot valid a", {31'd0, v8}, 32'd1);
      tick("rot");
      chk("rot valid b", {31'd0, v8}, 32'd1);
      tick("rot");
      chk("rot valid c", {31'd0, v8}, 32'd1);
      done8 = 1'b1;
      tick("rot");
      done8 = 1'b0;
    end

    // Watchdog: sole requester never finishes.
    do_reset();
    req8 = 8'h02;
    tick("wd");
    chk("wd first cnt", {16'd0, cnt8}, 32'd1);
    repeat (15) tick("wd");
    chk("wd cnt16", {16'd0, cnt8}, 32'd16);
    chk("wd no pulse yet", {31'd0, to8}, 32'd0);
    tick("wd");
    chk("wd pulse", {31'd0, to8}, 32'd1);
    chk("wd gnt off", {24'd0, gnt8}, 32'd0);
    chk("wd cnt off", {16'd0, cnt8}, 32'd0);
    tick("wd");
    chk("wd regrant", {24'd0, gnt8}, 32'h02);
    chk("wd pulse gone", {31'd0, to8}, 32'd0);

    // Async reset mid-grant, then pointer restarts at 0.
    do_reset();
    req8 = 8'h81;
    tick("rst");
    chk("rst first idx", {29'd0, idx8}, 32'd0);
    done8 = 1'b1;
    tick("rst");
    done8 = 1'b0;
    chk("rst second idx", {29'd0, idx8}, 32'd7);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async gnt", {24'd0, gnt8}, 32'd0);
    chk("async valid", {31'd0, v8}, 32'd0);
    m8 = model_reset();
    m7 = model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick("rst");
    chk("post-reset idx", {29'd0, idx8}, 32'd0);
    chk("post-reset valid", {31'd0, v8}, 32'd1);

    // N=7 wrap and counter saturation.
    do_reset();
    req7 = 7'h40;
    tick("n7");
    chk("n7 idx6", {29'd0, idx7}, 32'd6);
    req7  = 7'h41;
    done7 = 1'b1;
    tick("n7");
    done7 = 1'b0;
    chk("n7 wrap idx0", {29'd0, idx7}, 32'd0);
    req7 = 7'h01;
    repeat (20) tick("n7");
    chk("n7 saturate", {28'd0, cnt7}, 32'd15);

    // Randomised traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req8 = 8'($urandom);
      if ($urandom_range(7) == 0) req7 = 7'($urandom);
      done8 = ($urandom_range(9) == 0);
      done7 = ($urandom_range(9) == 0);
      if ($urandom_range(799) == 0) do_reset();
      else tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
